// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with byte-strobe writes,
// optional same-cycle write-to-read bypass, and a per-register busy
// scoreboard (allocate at issue, clear at writeback).
//
// There is no handshake: every enabled write, clear and allocate is
// accepted in the cycle it is presented. Register 0 is hardwired to zero,
// is never busy, and ignores writes, clears and allocations. Addresses that
// do not name a register (>= N_REGS) match nothing and so are ignored on
// writes and read back as zero / not busy.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS     = 32,
  parameter int N_RD       = 2,
  parameter int N_WR       = 2,
  parameter int BYPASS     = 1,
  parameter int ADDR_W     = $clog2(N_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_RD*ADDR_W-1:0]           rd_addr_i,
  output logic [N_RD*DATA_WIDTH-1:0]       rd_data_o,
  output logic [N_RD-1:0]                  rd_busy_o,
  input  logic [N_WR-1:0]                  wr_en_i,
  input  logic [N_WR*ADDR_W-1:0]           wr_addr_i,
  input  logic [N_WR*DATA_WIDTH-1:0]       wr_data_i,
  input  logic [N_WR*(DATA_WIDTH/8)-1:0]   wr_strb_i,
  input  logic [N_WR-1:0]                  wr_clr_i,
  input  logic                             alloc_en_i,
  input  logic [ADDR_W-1:0]                alloc_addr_i,
  output logic                             alloc_err_o,
  output logic [$clog2(N_REGS+1)-1:0]      busy_cnt_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(N_REGS + 1);

  // Entry 0 exists only as a constant-zero slot so every index is legal;
  // it is reset to zero and never written with anything else.
  logic [DATA_WIDTH-1:0] regs_q  [N_REGS];
  logic [DATA_WIDTH-1:0] wr_next [N_REGS];
  logic [N_REGS-1:0]     busy_q;
  logic [N_REGS-1:0]     busy_nxt;
  logic [N_REGS-1:0]     clr_hit;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  err_nxt;

  // Merge all write ports into the next register image. Ports are visited
  // in ascending order, so for each byte the highest-index port whose strobe
  // is set wins. A write with no strobes still contributes its clear.
  always_comb begin
    for (int r = 0; r < N_REGS; r++) begin
      wr_next[r] = regs_q[r];
      clr_hit[r] = 1'b0;
    end
    for (int r = 1; r < N_REGS; r++) begin
      for (int p = 0; p < N_WR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          if (wr_clr_i[p]) begin
            clr_hit[r] = 1'b1;
          end
          for (int b = 0; b < NB; b++) begin
            if (wr_strb_i[p*NB + b]) begin
              wr_next[r][b*8 +: 8] = wr_data_i[p*DATA_WIDTH + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Next scoreboard state: allocation beats a same-cycle clear; the busy
  // count is the population of the next busy vector, which equals the old
  // count plus set transitions minus clear transitions and cannot wrap.
  always_comb begin
    busy_nxt = '0;
    cnt_nxt  = '0;
    err_nxt  = 1'b0;
    for (int r = 0; r < N_REGS; r++) begin
      if (r != 0) begin
        busy_nxt[r] = (alloc_en_i && (alloc_addr_i == ADDR_W'(r))) ||
                      (busy_q[r] && !clr_hit[r]);
      end
      if (alloc_en_i && (alloc_addr_i == ADDR_W'(r)) && busy_q[r]) begin
        err_nxt = 1'b1;
      end
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
    end
  end

  // Read ports: bypassed (same-cycle merged state) or registered state,
  // forced to zero while reset is asserted.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    if (!rst) begin
      for (int k = 0; k < N_RD; k++) begin
        for (int r = 1; r < N_REGS; r++) begin
          if (rd_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
            if (BYPASS != 0) begin
              rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wr_next[r];
              rd_busy_o[k]                          = busy_nxt[r];
            end else begin
              rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
              rd_busy_o[k]                          = busy_q[r];
            end
          end
        end
      end
    end
  end

  // State update: synchronous reset discards everything presented in the
  // reset cycle; otherwise commit the merged registers and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q      <= '0;
      busy_cnt_o  <= '0;
      alloc_err_o <= 1'b0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        regs_q[r] <= wr_next[r];
      end
      busy_q      <= busy_nxt;
      busy_cnt_o  <= cnt_nxt;
      alloc_err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass and one without, driven by
// the same stimulus. The driver computes the expected outputs of each cycle
// from an array-based register-file model and queues them; the monitor pops
// and compares at the falling edge.
module tb_regfile_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;
  localparam int SW  = DW / 8;
  localparam int CW  = 6;
  localparam int EW  = 2*(NRD*DW + NRD) + CW + 1;

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*DW-1:0]    wr_data;
  logic [NWR*SW-1:0]    wr_strb;
  logic [NWR-1:0]       wr_clr;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_addr;

  logic [NRD*DW-1:0]    rd_data1, rd_data0;
  logic [NRD-1:0]       rd_busy1, rd_busy0;
  logic                 alloc_err1, alloc_err0;
  logic [CW-1:0]        busy_cnt1, busy_cnt0;

  regfile_sb #(.DATA_WIDTH(DW), .N_REGS(NR), .N_RD(NRD), .N_WR(NWR), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_busy_o(rd_busy1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .wr_clr_i(wr_clr), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .alloc_err_o(alloc_err1), .busy_cnt_o(busy_cnt1)
  );

  regfile_sb #(.DATA_WIDTH(DW), .N_REGS(NR), .N_RD(NRD), .N_WR(NWR), .BYPASS(0)) dut_reg (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .wr_clr_i(wr_clr), .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .alloc_err_o(alloc_err0), .busy_cnt_o(busy_cnt0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [DW-1:0] m_mem  [NR];
  logic          m_busy [NR];
  int            m_cnt;
  logic          m_err;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_strb    = '0;
    wr_clr     = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d,
                    input logic [SW-1:0] s, input logic c);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_data[p*DW +: DW]   = d;
    wr_strb[p*SW +: SW]   = s;
    wr_clr[p]             = c;
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = AW'(a);
  endtask

  task automatic rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  // Apply the current inputs for one cycle: derive the expected outputs
  // from the model, queue them, then advance the model across the edge.
  task automatic step();
    logic [DW-1:0]     nmem [NR];
    logic              nbusy[NR];
    logic              clr_req[NR];
    logic [NRD*DW-1:0] d1, d0;
    logic [NRD-1:0]    b1, b0;
    logic              nerr;
    int                sets, clrs, a;
    for (int r = 0; r < NR; r++) begin
      nmem[r]    = m_mem[r];
      nbusy[r]   = m_busy[r];
      clr_req[r] = 1'b0;
    end
    // Later ports overwrite earlier ones byte by byte.
    for (int p = 0; p < NWR; p++) begin
      a = int'(wr_addr[p*AW +: AW]);
      if (wr_en[p] && a != 0 && a < NR) begin
        for (int b = 0; b < SW; b++)
          if (wr_strb[p*SW + b]) nmem[a][b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
        if (wr_clr[p]) clr_req[a] = 1'b1;
      end
    end
    for (int r = 0; r < NR; r++)
      if (clr_req[r]) nbusy[r] = 1'b0;
    nerr = 1'b0;
    a = int'(alloc_addr);
    if (alloc_en && a != 0 && a < NR) begin
      nerr     = m_busy[a];
      nbusy[a] = 1'b1;
    end
    sets = 0;
    clrs = 0;
    for (int r = 0; r < NR; r++) begin
      if (!m_busy[r] && nbusy[r]) sets++;
      if (m_busy[r] && !nbusy[r]) clrs++;
    end
    d1 = '0; d0 = '0; b1 = '0; b0 = '0;
    for (int k = 0; k < NRD; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      if (!rst && a != 0 && a < NR) begin
        d1[k*DW +: DW] = nmem[a];
        b1[k]          = nbusy[a];
        d0[k*DW +: DW] = m_mem[a];
        b0[k]          = m_busy[a];
      end
    end
    exp_q.push_back({d1, b1, d0, b0, CW'(m_cnt), m_err});
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r]  = nmem[r];
        m_busy[r] = nbusy[r];
      end
      m_cnt = m_cnt + sets - clrs;
      m_err = nerr;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("byp_rd_data", 64'(rd_data1),   64'(mon_e[EW-1 -: NRD*DW]));
      chk("byp_rd_busy", 64'(rd_busy1),   64'(mon_e[EW-NRD*DW-1 -: NRD]));
      chk("reg_rd_data", 64'(rd_data0),   64'(mon_e[CW+1+NRD +: NRD*DW]));
      chk("reg_rd_busy", 64'(rd_busy0),   64'(mon_e[CW+1 +: NRD]));
      chk("byp_busy_cnt", 64'(busy_cnt1), 64'(mon_e[CW:1]));
      chk("reg_busy_cnt", 64'(busy_cnt0), 64'(mon_e[CW:1]));
      chk("byp_alloc_err", 64'(alloc_err1), 64'(mon_e[0]));
      chk("reg_alloc_err", 64'(alloc_err0), 64'(mon_e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    rst     = 1'b1;
    rd_addr = '0;
    idle();
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
    // Bring both instances out of their unknown power-up state first.
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a write and alloc pending, then sweep all addresses.
    wr(0, 5, 32'hCAFEF00D, 4'hF, 1'b0);
    alloc(6);
    rd(0, 5); rd(1, 6);
    step();
    rst = 1'b0;
    idle();
    for (int a = 0; a < NR; a += 2) begin
      rd(0, a); rd(1, a + 1);
      step();
    end

    // Full write then partial byte write to reg 5.
    wr(0, 5, 32'hDEADBEEF, 4'hF, 1'b0); rd(0, 5); rd(1, 5); step();
    idle(); wr(0, 5, 32'h000000AA, 4'h1, 1'b0); step();
    idle(); step();

    // Two ports hit reg 7; port 1 owns the low two bytes.
    wr(0, 7, 32'h11111111, 4'hF, 1'b0);
    wr(1, 7, 32'h22222222, 4'h3, 1'b0);
    rd(0, 7); rd(1, 5); step();
    idle(); step();

    // Scoreboard: allocate, re-allocate (error), clear 3 while allocating 4.
    alloc(3); rd(0, 3); rd(1, 4); step();
    idle(); step();
    alloc(3); step();
    idle(); step();
    wr(0, 3, 32'h0, 4'h0, 1'b1); alloc(4); step();
    idle(); step();

    // Allocate and clear reg 9 together; allocation wins.
    alloc(9); wr(1, 9, 32'h99999999, 4'hF, 1'b1); rd(0, 9); rd(1, 9); step();
    idle(); step();

    // Register 0 ignores writes, clears and allocations.
    wr(0, 0, 32'hFFFFFFFF, 4'hF, 1'b1); wr(1, 0, 32'hFFFFFFFF, 4'hF, 1'b0);
    alloc(0); rd(0, 0); rd(1, 0); step();
    idle(); step();

    // Reset in mid-stream with writes and allocations in flight.
    wr(0, 12, 32'h12121212, 4'hF, 1'b0); alloc(13); rd(0, 12); rd(1, 13); step();
    wr(1, 14, 32'h14141414, 4'hF, 1'b0); alloc(15); rst = 1'b1; rd(0, 14); step();
    rst = 1'b0; idle(); rd(0, 12); rd(1, 13); step();
    step();

    // Randomized traffic, addresses biased low so collisions are frequent.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      wr_en      = NWR'($urandom);
      wr_data    = {$urandom, $urandom};
      wr_strb    = (NWR*SW)'($urandom);
      wr_clr     = NWR'($urandom);
      alloc_en   = ($urandom_range(0, 1) == 1);
      for (int p = 0; p < NWR; p++)
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? NR - 1 : 11));
      alloc_addr = AW'($urandom_range(0, 11));
      for (int k = 0; k < NRD; k++)
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? NR - 1 : 11));
      step();
    end
    idle();
    rst = 1'b0;

    // Let the monitor drain the queue, bounded.
    waits = 0;
    while (exp_q.size() > 0 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain cycle=%0d got=%0d exp=0", cyc, exp_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
